// File: rtl/gpio_cmd_engine.sv
// Byte-command GPIO engine: parses opcode/bank/pin/data bytes from an rx stream,
// updates the output/enable registers and returns a single response byte.
//
//  state    | meaning
//  IDLE     | waiting for an opcode byte
//  GET_BANK | waiting for the bank byte
//  GET_PIN  | waiting for the pin byte
//  GET_DATA | waiting for the data byte
//  RESP     | response held on tx until taken
module gpio_cmd_engine #(
   parameter int NUM_BANKS      = 4,
   parameter int BANK_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                            clk,
   input  logic                            nRst,
   input  logic                            rx_valid,
   input  logic [7:0]                      rx_data,
   output logic                            rx_ready,
   output logic                            tx_valid,
   output logic [7:0]                      tx_data,
   input  logic                            tx_ready,
   input  logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_in,
   output logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_out,
   output logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_oe,
   output logic                            err_timeout
);

   localparam int W  = NUM_BANKS * BANK_WIDTH;
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   localparam logic [2:0] OP_READ_PIN   = 3'd0;
   localparam logic [2:0] OP_WRITE_PIN  = 3'd1;
   localparam logic [2:0] OP_CONFIG_PIN = 3'd2;
   localparam logic [2:0] OP_READ_BANK  = 3'd3;
   localparam logic [2:0] OP_WRITE_BANK = 3'd4;

   typedef enum logic [2:0] {IDLE, GET_BANK, GET_PIN, GET_DATA, RESP} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    sync_meta, sync_q;
   logic [2:0]      op_q;
   logic [7:0]      bank_q, pin_q;
   logic [CW-1:0]   tmo_cnt;

   logic            accept, in_get, tmo_last, tmo_fire;
   logic [7:0]      bank_v, pin_v;
   logic            bank_ok, pin_ok;
   logic [W-1:0]    bit_mask, bank_mask;
   logic            rd_bit;
   logic [BANK_WIDTH-1:0] rd_bank;
   logic [W-1:0]    out_nxt, oe_nxt;
   logic            resp_load;
   logic [7:0]      resp_nxt;

   assign rx_ready = (state != RESP);
   assign accept   = rx_valid && rx_ready;
   assign in_get   = (state == GET_BANK) || (state == GET_PIN) || (state == GET_DATA);
   assign tmo_last = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   // The final byte may itself be the bank or pin, so take it straight from rx_data.
   assign bank_v  = (state == GET_BANK) ? rx_data : bank_q;
   assign pin_v   = (state == GET_PIN)  ? rx_data : pin_q;
   assign bank_ok = (bank_v < 8'(NUM_BANKS));
   assign pin_ok  = (pin_v < 8'(BANK_WIDTH));

   always_comb begin
      bit_mask  = '0;
      bank_mask = '0;
      rd_bit    = 1'b0;
      rd_bank   = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_v == 8'(b)) begin
            bank_mask[b*BANK_WIDTH +: BANK_WIDTH] = '1;
            rd_bank = sync_q[b*BANK_WIDTH +: BANK_WIDTH];
            for (int p = 0; p < BANK_WIDTH; p++) begin
               if (pin_v == 8'(p)) begin
                  bit_mask[b*BANK_WIDTH+p] = 1'b1;
                  rd_bit = sync_q[b*BANK_WIDTH+p];
               end
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      out_nxt   = gpio_out;
      oe_nxt    = gpio_oe;
      resp_load = 1'b0;
      resp_nxt  = NAK;
      tmo_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (rx_data <= 8'h04) begin
                  state_nxt = GET_BANK;
               end else begin
                  resp_load = 1'b1;
                  state_nxt = RESP;
               end
            end
         end
         GET_BANK: begin
            if (accept) begin
               if (op_q == OP_WRITE_BANK) begin
                  state_nxt = GET_DATA;
               end else if (op_q == OP_READ_BANK) begin
                  resp_load = 1'b1;
                  state_nxt = RESP;
                  if (bank_ok) resp_nxt = 8'(rd_bank);
               end else begin
                  state_nxt = GET_PIN;
               end
            end
         end
         GET_PIN: begin
            if (accept) begin
               if (op_q == OP_READ_PIN) begin
                  resp_load = 1'b1;
                  state_nxt = RESP;
                  if (bank_ok && pin_ok) resp_nxt = {7'b0, rd_bit};
               end else begin
                  state_nxt = GET_DATA;
               end
            end
         end
         GET_DATA: begin
            if (accept) begin
               resp_load = 1'b1;
               state_nxt = RESP;
               case (op_q)
                  OP_WRITE_PIN: if (bank_ok && pin_ok) begin
                     out_nxt  = (gpio_out & ~bit_mask) | (bit_mask & {W{rx_data[0]}});
                     resp_nxt = ACK;
                  end
                  OP_CONFIG_PIN: if (bank_ok && pin_ok) begin
                     oe_nxt   = (gpio_oe & ~bit_mask) | (bit_mask & {W{rx_data[0]}});
                     resp_nxt = ACK;
                  end
                  OP_WRITE_BANK: if (bank_ok) begin
                     out_nxt  = (gpio_out & ~bank_mask) |
                                (bank_mask & {NUM_BANKS{rx_data[BANK_WIDTH-1:0]}});
                     resp_nxt = ACK;
                  end
                  default: ;
               endcase
            end
         end
         RESP: begin
            if (tx_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // An arriving byte always wins over an expiring timer.
      if (in_get && !accept && tmo_last) begin
         state_nxt = IDLE;
         tmo_fire  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state       <= IDLE;
         sync_meta   <= '0;
         sync_q      <= '0;
         gpio_out    <= '0;
         gpio_oe     <= '0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
         err_timeout <= 1'b0;
         tmo_cnt     <= '0;
         op_q        <= '0;
         bank_q      <= '0;
         pin_q       <= '0;
      end else begin
         state       <= state_nxt;
         sync_meta   <= gpio_in;
         sync_q      <= sync_meta;
         gpio_out    <= out_nxt;
         gpio_oe     <= oe_nxt;
         err_timeout <= tmo_fire;
         if (resp_load) begin
            tx_valid <= 1'b1;
            tx_data  <= resp_nxt;
         end else if ((state == RESP) && tx_ready) begin
            tx_valid <= 1'b0;
         end
         if (accept && (state == IDLE))     op_q   <= rx_data[2:0];
         if (accept && (state == GET_BANK)) bank_q <= rx_data;
         if (accept && (state == GET_PIN))  pin_q  <= rx_data;
         if (!in_get || accept || tmo_last) tmo_cnt <= '0;
         else                               tmo_cnt <= tmo_cnt + CW'(1);
      end
   end

endmodule

// File: doc/gpio_cmd_engine.md
GPIO_CMD_ENGINE -- requirements
Module: gpio_cmd_engine

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of GPIO banks, legal range 1..8.
REQ-002 SHALL have parameter BANK_WIDTH, default 8, pins per bank, legal range 1..8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle cycles allowed between bytes of one command, minimum 2.
REQ-004 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-005 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_valid  input  1  a command byte is present on rx_data.
REQ-007 SHALL have port rx_data  input  8  command byte.
REQ-008 SHALL have port rx_ready  output  1  engine accepts rx_data this cycle.
REQ-009 SHALL have port tx_valid  output  1  a response byte is present on tx_data.
REQ-010 SHALL have port tx_data  output  8  response byte.
REQ-011 SHALL have port tx_ready  input  1  downstream (UART transmitter) takes tx_data this cycle.
REQ-012 SHALL have port gpio_in  input  NUM_BANKS*BANK_WIDTH  pad inputs; asynchronous to clk.
REQ-013 SHALL have port gpio_out  output  NUM_BANKS*BANK_WIDTH  output data register.
REQ-014 SHALL have port gpio_oe  output  NUM_BANKS*BANK_WIDTH  output enable register; 1 = drive pin.
REQ-015 SHALL have port err_timeout  output  1  one-cycle pulse when an incomplete command is aborted.

Function
REQ-016 SHALL accept a byte only on a cycle where rx_valid=1 and rx_ready=1.
REQ-017 SHALL complete a tx transfer only on a cycle where tx_valid=1 and tx_ready=1.
REQ-018 SHALL address pin p of bank b as bit index b*BANK_WIDTH+p.
REQ-019 SHALL pass gpio_in through a two-flop synchronizer; all reads SHALL return the synchronized value.
REQ-020 SHALL implement states IDLE, GET_BANK, GET_PIN, GET_DATA and RESP.
REQ-021 SHALL assert rx_ready in every state except RESP.
REQ-022 SHALL interpret the byte accepted in IDLE as an opcode and SHALL handle opcodes as follows: 0x00 READ_PIN takes bank then pin; 0x01 WRITE_PIN takes bank, pin, data; 0x02 CONFIG_PIN takes bank, pin, data; 0x03 READ_BANK takes bank; 0x04 WRITE_BANK takes bank, data.
REQ-023 SHALL transition IDLE->GET_BANK on a valid opcode, GET_BANK->GET_PIN (opcodes 0x00-0x02), GET_BANK->GET_DATA (0x04), GET_PIN->GET_DATA (0x01, 0x02), and enter RESP on the final byte of a command.
REQ-024 SHALL, on the clock edge that accepts the final byte, update gpio_out/gpio_oe, load tx_data and set tx_valid=1, so the response is visible the following cycle.
REQ-025 SHALL execute commands as follows: READ_PIN responds {7'b0, pin}; WRITE_PIN sets gpio_out bit = data[0] and responds 0x06; CONFIG_PIN sets gpio_oe bit = data[0] and responds 0x06; READ_BANK responds with the bank inputs zero-extended to 8 bits; WRITE_BANK sets gpio_out[bank] = data[BANK_WIDTH-1:0] and responds 0x06.
REQ-026 SHALL respond 0x15 (NAK) and change no register when bank>=NUM_BANKS or pin>=BANK_WIDTH; the range check SHALL be applied at the final byte.
REQ-027 SHALL respond 0x15 and enter RESP directly from IDLE when the opcode is greater than 0x04.
REQ-028 SHALL hold tx_valid and tx_data stable in RESP until tx_ready=1, then clear tx_valid and return to IDLE on that edge.
REQ-029 SHALL run a timeout counter in GET_BANK, GET_PIN and GET_DATA that clears on every accepted byte.
REQ-030 SHALL, when the timeout counter reaches TIMEOUT_CYCLES-1 with no byte accepted, return to IDLE with no response and no register change, and pulse err_timeout for one cycle.
REQ-031 SHALL not apply the timeout in IDLE or RESP.
REQ-032 SHALL size the timeout counter using $clog2(TIMEOUT_CYCLES).

Reset
REQ-033 SHALL, while nRst=0, force state=IDLE, gpio_out=0, gpio_oe=0, tx_valid=0, tx_data=0, err_timeout=0, timeout counter=0, synchronizer flops=0.
REQ-034 SHALL abandon any partially received command or pending response when reset is asserted mid-operation; no response SHALL be sent after reset is released.

Verification
REQ-035 SHALL pass this scenario with defaults: bytes 01,02,05,01 -> gpio_out[21]=1 one cycle after the last byte; tx_data=0x06 with tx_valid held until tx_ready.
REQ-036 SHALL pass this scenario: bytes 02,00,03,01 then 00,00,03 with gpio_in[3]=1 for at least 3 cycles -> gpio_oe[3]=1; responses 0x06 then 0x01.
REQ-037 SHALL pass this scenario: bytes 04,01,A5 then 03,01 with gpio_in[15:8]=0x3C -> gpio_out[15:8]=0xA5; responses 0x06 then 0x3C.
REQ-038 SHALL pass this scenario: bytes 01,04,00,01 and bytes 00,00,08 -> each responds 0x15 with gpio_out unchanged; byte 07 -> 0x15 immediately.
REQ-039 SHALL pass this scenario with TIMEOUT_CYCLES=16: bytes 01,02 then idle 16 cycles -> err_timeout pulses once, no tx_valid; next byte 00 is parsed as an opcode.
REQ-040 SHALL pass this scenario: tx_ready held 0 for 10 cycles in RESP -> rx_ready=0 and tx_data stable throughout; nRst pulsed during RESP -> tx_valid=0 and gpio_out=0.
